// File: rtl/hash_table_pkg.sv
// hash_table_pkg: shared defaults and types for the LSH bucket store.
package hash_table_pkg;
    localparam int DEF_SKETCH_SIZE = 16;
    localparam int DEF_NUM_OF_BUCKETS = 256;
    localparam int DEF_BUCKET_SIZE = 16;
    localparam int DEF_MAX_WINDOWS = 512;
    localparam int BKT_W = $clog2(DEF_NUM_OF_BUCKETS);
    typedef logic [31:0] window_id_t;
    typedef logic [BKT_W-1:0] bkt_idx_t;
    typedef logic [31:0] count_t;
endpackage

// File: rtl/hash_table_query_counter.sv
// hash_table_query_counter: scores every window by its valid entries across the sketch's buckets.
module hash_table_query_counter
    import hash_table_pkg::*;
#(
    parameter int SKETCH_SIZE = DEF_SKETCH_SIZE,
    parameter int NUM_OF_BUCKETS = DEF_NUM_OF_BUCKETS,
    parameter int BUCKET_SIZE = DEF_BUCKET_SIZE,
    parameter int MAX_WINDOWS_IN_REFERENCE = DEF_MAX_WINDOWS
) (
    input  window_id_t tbl [NUM_OF_BUCKETS][BUCKET_SIZE],
    input  count_t     len [NUM_OF_BUCKETS],
    input  logic [$clog2(NUM_OF_BUCKETS)-1:0] sketch [SKETCH_SIZE],
    output count_t     cnt [MAX_WINDOWS_IN_REFERENCE]
);
    localparam int WW = MAX_WINDOWS_IN_REFERENCE > 1 ? $clog2(MAX_WINDOWS_IN_REFERENCE) : 1;

    // Walk entries rather than windows so cost scales with sketch*bucket, not window count.
    always_comb begin
        for (int w = 0; w < MAX_WINDOWS_IN_REFERENCE; w++) cnt[w] = '0;
        for (int i = 0; i < SKETCH_SIZE; i++)
            for (int j = 0; j < BUCKET_SIZE; j++)
                if (32'(j) < len[sketch[i]] && tbl[sketch[i]][j] < 32'(MAX_WINDOWS_IN_REFERENCE))
                    cnt[tbl[sketch[i]][j][WW-1:0]] = cnt[tbl[sketch[i]][j][WW-1:0]] + 32'd1;
    end
endmodule

// File: rtl/hash_table.sv
// hash_table: LSH bucket store; insert appends a window ID to each sketch bucket, query publishes per-window match counts.
module hash_table
    import hash_table_pkg::*;
#(
    parameter int SKETCH_SIZE = DEF_SKETCH_SIZE,
    parameter int NUM_OF_BUCKETS = DEF_NUM_OF_BUCKETS,
    parameter int BUCKET_SIZE = DEF_BUCKET_SIZE,
    parameter int MAX_WINDOWS_IN_REFERENCE = DEF_MAX_WINDOWS
) (
    input  logic       clk,
    input  logic       reset_hash_table,
    input  logic       is_insert,
    input  logic       is_query,
    input  window_id_t window_id,
    input  logic [$clog2(NUM_OF_BUCKETS)-1:0] hashed_sketch [SKETCH_SIZE],
    output count_t     count_bus [MAX_WINDOWS_IN_REFERENCE],
    output window_id_t theTable [NUM_OF_BUCKETS][BUCKET_SIZE],
    output count_t     tableLength [NUM_OF_BUCKETS]
);
    localparam int LW = BUCKET_SIZE > 1 ? $clog2(BUCKET_SIZE) : 1;

    window_id_t tbl_q [NUM_OF_BUCKETS][BUCKET_SIZE];
    window_id_t tbl_d [NUM_OF_BUCKETS][BUCKET_SIZE];
    count_t     len_q [NUM_OF_BUCKETS];
    count_t     len_d [NUM_OF_BUCKETS];
    count_t     count_q [MAX_WINDOWS_IN_REFERENCE];
    count_t     count_d [MAX_WINDOWS_IN_REFERENCE];
    count_t     cnt_n [MAX_WINDOWS_IN_REFERENCE];

    // Query scores the registered (pre-insert) table.
    hash_table_query_counter #(
        .SKETCH_SIZE(SKETCH_SIZE),
        .NUM_OF_BUCKETS(NUM_OF_BUCKETS),
        .BUCKET_SIZE(BUCKET_SIZE),
        .MAX_WINDOWS_IN_REFERENCE(MAX_WINDOWS_IN_REFERENCE)
    ) u_counter (
        .tbl(tbl_q),
        .len(len_q),
        .sketch(hashed_sketch),
        .cnt(cnt_n)
    );

    // Slots are applied in order so repeated buckets see each other's appends.
    always_comb begin
        tbl_d = tbl_q;
        len_d = len_q;
        if (is_insert)
            for (int i = 0; i < SKETCH_SIZE; i++)
                if (len_d[hashed_sketch[i]] < 32'(BUCKET_SIZE)) begin
                    tbl_d[hashed_sketch[i]][len_d[hashed_sketch[i]][LW-1:0]] = window_id;
                    len_d[hashed_sketch[i]] = len_d[hashed_sketch[i]] + 32'd1;
                end
    end

    always_comb begin
        for (int w = 0; w < MAX_WINDOWS_IN_REFERENCE; w++) count_d[w] = is_query ? cnt_n[w] : count_q[w];
    end

    always_ff @(posedge clk or posedge reset_hash_table) begin
        if (reset_hash_table) begin
            for (int b = 0; b < NUM_OF_BUCKETS; b++) begin
                len_q[b] <= '0;
                for (int j = 0; j < BUCKET_SIZE; j++) tbl_q[b][j] <= '0;
            end
            for (int w = 0; w < MAX_WINDOWS_IN_REFERENCE; w++) count_q[w] <= '0;
        end else begin
            tbl_q <= tbl_d;
            len_q <= len_d;
            count_q <= count_d;
        end
    end

    assign theTable = tbl_q;
    assign tableLength = len_q;
    assign count_bus = count_q;
endmodule

// File: tb/tb_hash_table.sv
// tb_hash_table: directed stimulus pushes expected observations; a negedge monitor drains and compares them.
module tb_hash_table;
    logic        clk = 0;
    logic        rst = 0;
    logic        is_insert = 0;
    logic        is_query = 0;
    logic [31:0] window_id = 0;
    logic [7:0]  hs [16];
    logic [31:0] count_bus [512];
    logic [31:0] the_table [256][16];
    logic [31:0] table_length [256];

    typedef struct {
        string       name;
        int          kind;
        int          a;
        int          b;
        logic [31:0] exp;
    } chk_t;

    chk_t sb [$];
    int checks = 0;
    int errors = 0;

    hash_table dut (
        .clk(clk),
        .reset_hash_table(rst),
        .is_insert(is_insert),
        .is_query(is_query),
        .window_id(window_id),
        .hashed_sketch(hs),
        .count_bus(count_bus),
        .theTable(the_table),
        .tableLength(table_length)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string name, input int kind, input int a, input int b, input logic [31:0] exp);
        chk_t c;
        c.name = name; c.kind = kind; c.a = a; c.b = b; c.exp = exp;
        sb.push_back(c);
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < 16; i++) hs[i] = 8'(v);
    endtask

    task automatic op(input logic ins, input logic qry, input int wid);
        @(negedge clk);
        is_insert = ins;
        is_query = qry;
        window_id = 32'(wid);
        @(posedge clk);
        #1;
        is_insert = 0;
        is_query = 0;
    endtask

    // Reset is raised with an insert strobe present to confirm strobes are ignored.
    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        is_insert = 1;
        window_id = 32'd77;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 0;
        is_insert = 0;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            chk_t c;
            logic [31:0] act;
            c = sb.pop_front();
            act = c.kind == 0 ? table_length[c.a] : c.kind == 1 ? the_table[c.a][c.b] : count_bus[c.a];
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d", c.name, act, c.exp);
            end
        end
    end

    initial begin
        set_all(0);
        do_reset();
        expect_val("rst_len0", 0, 0, 0, 0);
        expect_val("rst_len1", 0, 1, 0, 0);
        expect_val("rst_tbl00", 1, 0, 0, 0);
        expect_val("rst_cnt0", 2, 0, 0, 0);
        expect_val("rst_cnt14", 2, 14, 0, 0);

        op(1, 0, 14);
        expect_val("ins_len0", 0, 0, 0, 16);
        expect_val("ins_tbl00", 1, 0, 0, 14);
        expect_val("ins_tbl0_15", 1, 0, 15, 14);
        expect_val("ins_len1", 0, 1, 0, 0);
        expect_val("ins_cnt14", 2, 14, 0, 0);

        op(0, 1, 0);
        expect_val("q_cnt14", 2, 14, 0, 256);
        expect_val("q_cnt0", 2, 0, 0, 0);
        expect_val("q_cnt1", 2, 1, 0, 0);
        expect_val("q_cnt511", 2, 511, 0, 0);
        expect_val("q_len0", 0, 0, 0, 16);

        op(1, 0, 3);
        expect_val("ovf_len0", 0, 0, 0, 16);
        expect_val("ovf_tbl0_15", 1, 0, 15, 14);
        op(0, 1, 0);
        expect_val("ovf_cnt3", 2, 3, 0, 0);
        expect_val("ovf_cnt14", 2, 14, 0, 256);

        op(0, 0, 0);
        expect_val("hold_cnt14", 2, 14, 0, 256);

        do_reset();
        for (int i = 0; i < 16; i++) hs[i] = 8'(i);
        op(1, 0, 5);
        expect_val("dist_len0", 0, 0, 0, 1);
        expect_val("dist_len15", 0, 15, 0, 1);
        expect_val("dist_tbl15_0", 1, 15, 0, 5);
        set_all(200);
        hs[0] = 0;
        op(1, 0, 7);
        expect_val("dist_len0b", 0, 0, 0, 2);
        expect_val("dist_tbl0_1", 1, 0, 1, 7);
        expect_val("dist_len200", 0, 200, 0, 15);
        set_all(0);
        op(0, 1, 0);
        expect_val("dist_cnt5", 2, 5, 0, 16);
        expect_val("dist_cnt7", 2, 7, 0, 16);
        for (int i = 0; i < 16; i++) hs[i] = 8'(i);
        op(0, 1, 0);
        expect_val("dist2_cnt5", 2, 5, 0, 16);
        expect_val("dist2_cnt7", 2, 7, 0, 1);

        set_all(50);
        op(1, 1, 9);
        expect_val("same_cnt9", 2, 9, 0, 0);
        expect_val("same_cnt5", 2, 5, 0, 0);
        expect_val("same_len50", 0, 50, 0, 16);
        op(0, 1, 0);
        expect_val("next_cnt9", 2, 9, 0, 256);

        set_all(60);
        op(1, 0, 600);
        expect_val("big_tbl60_0", 1, 60, 0, 600);
        hs[0] = 50;
        op(0, 1, 0);
        expect_val("big_cnt88", 2, 88, 0, 0);
        expect_val("big_cnt9", 2, 9, 0, 16);

        do_reset();
        expect_val("rst2_len50", 0, 50, 0, 0);
        expect_val("rst2_tbl50_0", 1, 50, 0, 0);
        expect_val("rst2_cnt9", 2, 9, 0, 0);
        expect_val("rst2_len77", 0, 0, 0, 0);

        for (int n = 0; n < 100 && sb.size() > 0; n++) @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d pending expected 0", sb.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hash_table.md
# hash_table

LSH bucket store for the reference-indexing pipeline. In insert mode it appends a reference window ID to every bucket named by the current hashed sketch. In query mode it scores every reference window by how many bucket entries among the sketch's buckets match it, and publishes a per-window count vector. It sits after the sketch/h2 hashing stage and feeds the candidate-selection logic.

## Interface
Parameters:
- SKETCH_SIZE, 16, number of hashed K-mer values per sketch
- NUM_OF_BUCKETS, 256, number of buckets; bucket index width is $clog2(NUM_OF_BUCKETS)
- BUCKET_SIZE, 16, entries per bucket
- MAX_WINDOWS_IN_REFERENCE, 512, number of count_bus lanes (window IDs 0..MAX-1)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- reset_hash_table  in  1  async active-high reset
- is_insert  in  1  insert strobe, sampled on rising clk
- is_query  in  1  query strobe, sampled on rising clk
- window_id  in  32  window ID to insert
- hashed_sketch  in  [SKETCH_SIZE] x $clog2(NUM_OF_BUCKETS)  bucket index per sketch slot
- count_bus  out  [MAX_WINDOWS_IN_REFERENCE] x 32  per-window match count from the last query
- theTable  out  [NUM_OF_BUCKETS][BUCKET_SIZE] x 32  bucket contents (debug/observe)
- tableLength  out  [NUM_OF_BUCKETS] x 32  valid entries per bucket

## Operation
- Reset: every theTable entry = 0, every tableLength = 0, every count_bus lane = 0.
- Insert (is_insert=1 at an edge):
  - Process slots i = 0..SKETCH_SIZE-1 in order.
  - Each slot appends window_id at theTable[b][tableLength[b]] with b = hashed_sketch[i], then increments tableLength[b].
  - Repeated indices within one sketch append repeatedly: 16 slots all equal to 0 add 16 entries to bucket 0.
  - A full bucket (length == BUCKET_SIZE) silently drops the append; its length saturates at BUCKET_SIZE.
- Query (is_query=1 at an edge):
  - count_bus is fully recomputed; lanes do not accumulate across queries.
  - count_bus[w] = sum over slots i of the number of valid entries (index < tableLength[b]) in bucket b = hashed_sketch[i] equal to w.
  - A repeated bucket index counts again for each slot.
  - Entries with value ≥ MAX_WINDOWS_IN_REFERENCE are ignored.
  - Stale data beyond tableLength is never counted.
- Insert and query in the same edge: both execute; the query scores the pre-insert table.
- Neither strobe asserted: all state holds; count_bus holds the last query result.

## Timing
- Fully synchronous to rising clk except reset.
- Insert: theTable/tableLength updated at the strobing edge; visible immediately after it.
- Query: count_bus registered at the strobing edge; 1-cycle latency; no handshake and no busy state.
- Strobes are single-cycle qualifiers; back-to-back operations on consecutive edges are legal.
- Reset asserted mid-operation clears all state immediately; any strobe while reset is high is ignored.
- Count width is 32 bits; the maximum possible count is SKETCH_SIZE*BUCKET_SIZE, so no overflow handling is needed.

## Structure
- Package hash_table_pkg: default parameter constants, BKT_W = $clog2(NUM_OF_BUCKETS), and typedefs for window ID (32b), bucket index, and count (32b).
- Sub-module hash_table_query_counter:
  - Combinational.
  - Inputs: table, lengths, sketch.
  - Output: next count vector.
- The top level holds the table/length registers, the sequential insert loop, and the count_bus register.

## Test plan
- Reset: all hashed_sketch=0, pulse reset -> tableLength[0]=0, tableLength[1]=0, theTable[0][0]=0, count_bus[0]=0, count_bus[14]=0.
- Insert window_id=14, sketch all 0, one edge -> tableLength[0]=16, theTable[0][0..15]=14, tableLength[1]=0, count_bus unchanged (0).
- Then query, sketch all 0 -> count_bus[14]=256, count_bus[0]=0, all other lanes 0; table unchanged.
- Overflow: insert again into the full bucket 0 with window_id=3 -> tableLength[0] stays 16, no 3 stored; a query then gives count_bus[3]=0.
- Distinct buckets: sketch = 0..15, insert window 5, then insert window 7 with sketch slot 0=0 and others=200 -> query with sketch all 0 gives count_bus[5]=16, count_bus[7]=16.
- Same-edge insert and query of window 9 into empty buckets -> count_bus[9]=0 after that edge; the next query -> count_bus[9]>0.
